// File: rtl/sim_irq_stim.sv
// sim_irq_stim
// ------------
// Interrupt and stimulus generator for the pipelined OTTER simulation top.
// It drives NUM_CH interrupt lines. Channel 0 is the timer interrupt and
// channel 1 is the machine external interrupt. Each channel runs on its own
// and has three modes:
//   00 periodic pulse : PERIOD cycles low, then WIDTH cycles high, repeating
//   01 one-shot pulse : PERIOD cycles low, then WIDTH cycles high, then quiet
//                       until ENABLE is dropped
//   10 level-until-ack: PERIOD cycles low, then high until ACK is sampled
//   11 reserved, behaves like 00
// A free-running, saturating cycle counter is always built.
//
// Optional feature (compile-time macro SIM_IRQ_TIMEOUT_EN):
//   DONE is a sticky flag. It rises on the edge where CYCLES reaches
//   TIMEOUT_CYCLES. While DONE is high, every channel is held idle and
//   config writes are dropped. When the macro is undefined, DONE is tied
//   low and no comparator is built.
//
// Parameters:
//   NUM_CH         number of interrupt channels (1..8)
//   CNT_W          width of the period, width and phase counters
//   DEF_PERIOD     reset value of every channel's PERIOD register
//   TIMEOUT_CYCLES CYCLES value at which DONE asserts (timeout build only)
//
// Ports:
//   clk        in  single clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   cfg_we     in  configuration write strobe
//   cfg_ch     in  channel selected for the write (out of range = ignored)
//   cfg_period in  low-phase length in cycles (0 behaves as 1)
//   cfg_width  in  high-phase length in cycles (0 behaves as 1)
//   cfg_mode   in  channel mode, see above
//   enable     in  per-channel run enable (level)
//   ack        in  per-channel acknowledge, honoured only while holding
//   irq        out registered interrupt lines
//   cycles     out free-running saturating cycle counter
//   done       out sticky timeout flag

module sim_irq_stim #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 16,
    parameter int DEF_PERIOD     = 50,
    parameter int TIMEOUT_CYCLES = 200,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [1:0]        cfg_mode,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] irq,
    output logic [31:0]       cycles,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, SPENT} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [31:0] cycles_nxt;
    logic        halt;

    // The cycle counter stops at all-ones instead of wrapping.
    assign cycles_nxt = (cycles == '1) ? cycles : cycles + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycles <= '0;
        else        cycles <= cycles_nxt;
    end

`ifdef SIM_IRQ_TIMEOUT_EN
    logic done_nxt;

    // The channels are halted from the same edge that raises DONE.
    // That way IRQ never stays high for a cycle after DONE is seen.
    assign done_nxt = done | (cycles_nxt == 32'(TIMEOUT_CYCLES));
    assign halt     = done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= done_nxt;
    end
`else
    assign done = 1'b0;
    assign halt = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] len;
        logic [CNT_W-1:0] period_r;
        logic [CNT_W-1:0] width_r;
        logic [1:0]       mode_r;
        logic [1:0]       cur_mode;
        logic             irq_q;
        logic             wr_sel;
        logic [CNT_W-1:0] period_eff;
        logic [CNT_W-1:0] width_eff;

        assign wr_sel     = cfg_we && !halt && (32'(cfg_ch) == g);
        assign period_eff = (period_r == '0) ? ONE : period_r;
        assign width_eff  = (width_r == '0) ? ONE : width_r;
        assign irq[g]     = irq_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                period_r <= CNT_W'(DEF_PERIOD);
                width_r  <= ONE;
                mode_r   <= 2'b00;
            end else if (wr_sel) begin
                period_r <= cfg_period;
                width_r  <= cfg_width;
                mode_r   <= cfg_mode;
            end
        end

        // The phase length (len) and the mode are latched when a phase
        // begins. A config write landing mid-phase, or on the edge a phase
        // starts, only affects the following phase.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= IDLE;
                cnt      <= '0;
                len      <= '0;
                cur_mode <= 2'b00;
                irq_q    <= 1'b0;
            end else if (halt || !enable[g]) begin
                state <= IDLE;
                cnt   <= '0;
                irq_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= LOW;
                        cnt      <= '0;
                        len      <= period_eff;
                        cur_mode <= mode_r;
                        irq_q    <= 1'b0;
                    end
                    LOW: begin
                        if (cnt == len - ONE) begin
                            cnt   <= '0;
                            irq_q <= 1'b1;
                            if (cur_mode == 2'b10) begin
                                state <= HOLD;
                            end else begin
                                state <= HIGH;
                                len   <= width_eff;
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    HIGH: begin
                        if (cnt == len - ONE) begin
                            cnt   <= '0;
                            irq_q <= 1'b0;
                            if (cur_mode == 2'b01) begin
                                state <= SPENT;
                            end else begin
                                state    <= LOW;
                                len      <= period_eff;
                                cur_mode <= mode_r;
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    HOLD: begin
                        if (ack[g]) begin
                            state    <= LOW;
                            cnt      <= '0;
                            irq_q    <= 1'b0;
                            len      <= period_eff;
                            cur_mode <= mode_r;
                        end
                    end
                    SPENT: begin
                        irq_q <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        irq_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sim_irq_stim.sv
// tb_sim_irq_stim
// ---------------
// Self-checking bench for sim_irq_stim with two channels.
// Expected IRQ, CYCLES and DONE values are pushed to a queue while the
// stimulus is set up. They are popped and compared once per cycle, on the
// falling clock edge.
// In the default build the bench covers periodic, level and one-shot modes,
// zero-length registers, mid-phase writes and reset. With SIM_IRQ_TIMEOUT_EN
// defined it covers the timeout behaviour instead.

module tb_sim_irq_stim;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [0:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_width;
    logic [1:0]        cfg_mode;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] irq;
    logic [31:0]       cycles;
    logic              done;

    typedef struct {
        string       tag;
        logic [1:0]  irq;
        logic [31:0] cyc;
        logic        done;
    } exp_t;

    exp_t expQ[$];
    int   expCyc     = 0;
    int   errCount   = 0;
    int   checkCount = 0;

    sim_irq_stim #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEF_PERIOD(50),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_width(cfg_width),
        .cfg_mode(cfg_mode),
        .enable(enable),
        .ack(ack),
        .irq(irq),
        .cycles(cycles),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic doneModel(input int c);
`ifdef SIM_IRQ_TIMEOUT_EN
        return (c >= TIMEOUT);
`else
        return (c < 0);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input int period, input int width, input int mode);
        cfg_we     = 1'b1;
        cfg_ch     = 1'(ch);
        cfg_period = CNT_W'(period);
        cfg_width  = CNT_W'(width);
        cfg_mode   = 2'(mode);
    endtask

    task automatic pushIrq(input string tag, input logic [1:0] v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            expCyc++;
            e.tag  = tag;
            e.irq  = v;
            e.cyc  = 32'(expCyc);
            e.done = doneModel(expCyc);
            expQ.push_back(e);
        end
    endtask

    task automatic pushWave(input string tag, input int ch, input int lo, input int hi, input int reps);
        logic [1:0] hv;
        hv = 2'(1 << ch);
        for (int r = 0; r < reps; r++) begin
            pushIrq(tag, 2'b00, lo);
            pushIrq(tag, hv, hi);
        end
    endtask

    task automatic runCycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.tag, "_irq"}, 32'(irq), 32'(e.irq));
                checkOutput({e.tag, "_cyc"}, cycles, e.cyc);
                checkOutput({e.tag, "_done"}, 32'(done), 32'(e.done));
            end
            cfg_we = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_width  = '0;
        cfg_mode   = 2'b00;
        enable     = '0;
        ack        = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_cyc", cycles, 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst_n  = 1'b1;
        expCyc = 0;

`ifdef SIM_IRQ_TIMEOUT_EN
        // Timeout: IRQ high from cycle 4, then forced low once DONE rises at 20.
        applyStimulus(0, 2, 30, 0);
        pushIrq("to_cfg", 2'b00, 1);
        runCycles(1);
        enable = 2'b01;
        for (int n = 2; n <= 21; n++)
            pushIrq("to_run", (n >= 4 && n < TIMEOUT) ? 2'b01 : 2'b00, 1);
        runCycles(20);
        applyStimulus(0, 1, 1, 0);
        enable = 2'b00;
        pushIrq("to_poke", 2'b00, 1);
        runCycles(1);
        enable = 2'b01;
        pushIrq("to_held", 2'b00, 3);
        runCycles(3);
`else
        // Periodic: 4 low, 2 high, three full cycles.
        applyStimulus(0, 4, 2, 0);
        pushIrq("t1_cfg", 2'b00, 1);
        runCycles(1);
        enable = 2'b01;
        pushWave("t1_periodic", 0, 4, 2, 3);
        runCycles(18);
        enable = 2'b00;
        pushIrq("t1_off", 2'b00, 1);
        runCycles(1);

        // Level mode: ACK raised 5 cycles after the rise gives 6 high, then 3 low.
        applyStimulus(1, 3, 1, 2);
        pushIrq("t2_cfg", 2'b00, 1);
        runCycles(1);
        enable = 2'b10;
        pushIrq("t2_low", 2'b00, 3);
        pushIrq("t2_hold", 2'b10, 6);
        runCycles(9);
        ack = 2'b10;
        pushIrq("t2_relow", 2'b00, 3);
        runCycles(1);
        ack = 2'b00;
        runCycles(2);
        pushIrq("t2_rehold", 2'b10, 2);
        runCycles(2);
        enable = 2'b00;
        pushIrq("t2_en_drop", 2'b00, 1);
        runCycles(1);

        // Level mode with ACK held: 1 high, 3 low.
        ack    = 2'b10;
        enable = 2'b10;
        pushWave("t2_ackheld", 1, 3, 1, 3);
        runCycles(12);
        enable = 2'b00;
        ack    = 2'b00;
        pushIrq("t2_off", 2'b00, 1);
        runCycles(1);

        // One-shot: a single 3-cycle pulse, re-armed by toggling ENABLE.
        applyStimulus(0, 2, 3, 1);
        pushIrq("t3_cfg", 2'b00, 1);
        runCycles(1);
        enable = 2'b01;
        pushWave("t3_shot", 0, 2, 3, 1);
        pushIrq("t3_spent", 2'b00, 6);
        runCycles(11);
        enable = 2'b00;
        pushIrq("t3_off", 2'b00, 1);
        runCycles(1);
        enable = 2'b01;
        pushWave("t3_shot2", 0, 2, 3, 1);
        pushIrq("t3_spent2", 2'b00, 3);
        runCycles(8);
        enable = 2'b00;
        pushIrq("t3_off2", 2'b00, 1);
        runCycles(1);

        // Zero PERIOD and WIDTH behave as 1.
        applyStimulus(0, 0, 0, 0);
        pushIrq("t4_cfg", 2'b00, 1);
        runCycles(1);
        enable = 2'b01;
        pushWave("t4_zero", 0, 1, 1, 3);
        runCycles(6);
        enable = 2'b00;
        pushIrq("t4_off", 2'b00, 1);
        runCycles(1);

        // A write during HIGH applies at the next LOW.
        // A write on a LOW start edge waits one more phase.
        applyStimulus(0, 2, 3, 0);
        pushIrq("t4b_cfg", 2'b00, 1);
        runCycles(1);
        enable = 2'b01;
        pushIrq("t4b_low", 2'b00, 2);
        pushIrq("t4b_high", 2'b01, 1);
        runCycles(3);
        applyStimulus(0, 10, 3, 0);
        pushIrq("t4b_high", 2'b01, 2);
        pushIrq("t4b_low10", 2'b00, 10);
        pushIrq("t4b_high", 2'b01, 3);
        runCycles(15);
        applyStimulus(0, 1, 3, 0);
        pushIrq("t4b_oldlow", 2'b00, 10);
        pushIrq("t4b_high", 2'b01, 3);
        pushIrq("t4b_low1", 2'b00, 1);
        pushIrq("t4b_high1", 2'b01, 1);
        runCycles(15);

        // Reset mid-pulse drops IRQ at once and restores defaults.
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_irq", 32'(irq), 32'd0);
        checkOutput("rst_mid_cyc", cycles, 32'd0);
        @(negedge clk);
        checkOutput("rst_hold_irq", 32'(irq), 32'd0);
        rst_n  = 1'b1;
        expCyc = 0;
        pushIrq("t5_deflow", 2'b00, 50);
        pushIrq("t5_defhigh", 2'b01, 1);
        pushIrq("t5_deflow2", 2'b00, 1);
        runCycles(52);
        enable = 2'b00;
`endif

        checkOutput("sb_leftover", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
